// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder.
//   SEG_A..SEG_G, SEG_DP : bit positions within the active-low segment bus
//   SEG_BLANK            : all segments and the dot off (active-low)
//   GLYPHS[v]            : active-low pattern {g..a} for hex value v; this is
//                          the same table the hex-to-segment encoder drives
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Element 0 is the rightmost entry, so GLYPHS[0] is the glyph for '0'.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Pin-side bundle of the scan decoder.
//   seg_n   : active-low segments, bit0..6 = a..g, bit7 = dot
//   dig_n   : active-low digit selects
//   digits  : decoded hex, digit k at [4k+3:4k]
//   dots    : 1 = dot lit on digit k
//   invalid : 1 = last capture for digit k matched no glyph (or none yet)
//   update  : one-cycle strobe when any of digits/dots/invalid changed
// There is no backpressure: seg_n/dig_n are sampled every cycle, and update
// is a pure strobe that a consumer must catch in the cycle it is high.
interface seg7_scan_decoder_if #(
    parameter int N_DIGITS = 4
);
    logic [7:0]            seg_n;
    logic [N_DIGITS-1:0]   dig_n;
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   dots;
    logic [N_DIGITS-1:0]   invalid;
    logic                  update;

    // master: the display driver side plus whoever consumes the results
    modport master (
        output seg_n, dig_n,
        input  digits, dots, invalid, update
    );

    // slave: the decoder itself
    modport slave (
        input  seg_n, dig_n,
        output digits, dots, invalid, update
    );
endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph lookup: active-low {g..a} pattern to hex value.
//   pattern : 7-bit active-low segment pattern
//   hex     : matched hex value (0 when no match)
//   match   : 1 when pattern equals one of the 16 glyphs
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] hex,
    output logic       match
);

    // Glyphs are all distinct, so at most one iteration can hit.
    always_comb begin
        hex   = 4'h0;
        match = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPHS[i]) begin
                hex   = 4'(i);
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of the multiplexed seven-segment bus: synchronizes the pins,
// waits for a pattern to be stable for STABLE_CYCLES samples, then captures
// the decoded hex value, dot and validity into the selected digit's registers.
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : seg7_scan_decoder_if.slave (pins in, decoded results out)
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    seg7_scan_decoder_if.slave bus
);

    localparam int W     = N_DIGITS + 8;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    // Counter value from which the next increment reaches STABLE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_PRE =
        (STABLE_CYCLES >= 2) ? CNT_W'(STABLE_CYCLES - 2) : '0;

    // {dig_n, seg_n} at each stage
    logic [W-1:0]     sync1, sample, prev, filt;
    logic [CNT_W-1:0] cnt;
    logic             accept, accept_next;

    logic [4*N_DIGITS-1:0] digits_q, digits_next;
    logic [N_DIGITS-1:0]   dots_q, dots_next;
    logic [N_DIGITS-1:0]   invalid_q, invalid_next;
    logic                  update_q, changed;

    logic [N_DIGITS-1:0] sel;
    logic [7:0]          filt_seg;
    logic                one_hot;
    logic [3:0]          hex;
    logic                match;

    // accept is registered, so it lines up with filt, which holds the
    // sample that was just proven stable.
    always_comb begin
        if (STABLE_CYCLES == 1) begin
            accept_next = (sample != prev);
        end else begin
            accept_next = (sample == prev) && (cnt == CNT_PRE);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1  <= '1;
            sample <= '1;
            prev   <= '1;
            filt   <= '1;
            cnt    <= '0;
            accept <= 1'b0;
        end else begin
            sync1  <= {bus.dig_n, bus.seg_n};
            sample <= sync1;
            prev   <= sample;
            filt   <= sample;
            accept <= accept_next;
            if (sample != prev) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign filt_seg = filt[7:0];
    assign sel      = ~filt[W-1:8];
    // Blanking (no select) and ghosting (several selects) are both ignored.
    assign one_hot  = $onehot(sel);

    seg7_glyph_decode u_decode (
        .pattern (filt_seg[6:0]),
        .hex     (hex),
        .match   (match)
    );

    always_comb begin
        digits_next  = digits_q;
        dots_next    = dots_q;
        invalid_next = invalid_q;
        if (accept && one_hot) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                if (sel[k]) begin
                    digits_next[4*k +: 4] = match ? hex : 4'h0;
                    dots_next[k]          = ~filt_seg[SEG_DP];
                    invalid_next[k]       = ~match;
                end
            end
        end
        changed = ({digits_next, dots_next, invalid_next}
                   != {digits_q, dots_q, invalid_q});
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            digits_q  <= '0;
            dots_q    <= '0;
            invalid_q <= '1;
            update_q  <= 1'b0;
        end else begin
            digits_q  <= digits_next;
            dots_q    <= dots_next;
            invalid_q <= invalid_next;
            update_q  <= changed;
        end
    end

    assign bus.digits  = digits_q;
    assign bus.dots    = dots_q;
    assign bus.invalid = invalid_q;
    assign bus.update  = update_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

    logic clock;
    logic reset_n;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   upd_cnt      = 0;

    // Independent copy of the encoder's glyph table, g..a active-low.
    localparam logic [6:0] ENC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg7_scan_decoder_if #(.N_DIGITS(4)) bus ();

    seg7_scan_decoder #(
        .N_DIGITS      (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (bus.update === 1'b1) upd_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers ----------------
    // Drive pins at a falling edge and hold them for n rising edges.
    task automatic hold(input logic [7:0] seg, input logic [3:0] dig, input int n);
        bus.seg_n = seg;
        bus.dig_n = dig;
        repeat (n) @(negedge clock);
    endtask

    task automatic idle(input int n);
        hold(8'hFF, 4'hF, n);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int base;
        reset_n = 1'b0;
        bus.seg_n = 8'hFF;
        bus.dig_n = 4'hF;
        repeat (2) @(negedge clock);
        tests_run++;
        if (bus.digits !== 16'h0000 || bus.dots !== 4'h0 || bus.invalid !== 4'hF || bus.update !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: got digits=%h dots=%b invalid=%b update=%b, want 0000 0000 1111 0",
                     bus.digits, bus.dots, bus.invalid, bus.update);
        end
        reset_n = 1'b1;
        base = upd_cnt;
        idle(20);
        tests_run++;
        if (bus.digits !== 16'h0000 || bus.dots !== 4'h0 || bus.invalid !== 4'hF) begin
            tests_failed++;
            $display("FAIL idle_outputs: got digits=%h dots=%b invalid=%b, want 0000 0000 1111",
                     bus.digits, bus.dots, bus.invalid);
        end
        tests_run++;
        if (upd_cnt - base !== 0) begin
            tests_failed++;
            $display("FAIL idle_update: got %0d pulses, want 0", upd_cnt - base);
        end
    endtask

    task automatic test_single_digit();
        int base;
        base = upd_cnt;
        // glyph 4, dot off, digit 0; pins present before E0
        hold(8'h99, 4'hE, 6);   // edges E0..E5 passed
        tests_run++;
        if (bus.invalid[0] !== 1'b1 || bus.digits[3:0] !== 4'h0) begin
            tests_failed++;
            $display("FAIL latency_early: got digit0=%h invalid0=%b after E0+5, want 0 1",
                     bus.digits[3:0], bus.invalid[0]);
        end
        @(negedge clock);       // E6 passed
        tests_run++;
        if (bus.digits[3:0] !== 4'h4 || bus.invalid[0] !== 1'b0 || bus.dots[0] !== 1'b0 || bus.update !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_capture: got digit0=%h invalid0=%b dot0=%b update=%b, want 4 0 0 1",
                     bus.digits[3:0], bus.invalid[0], bus.dots[0], bus.update);
        end
        repeat (3) @(negedge clock);
        idle(10);
        tests_run++;
        if (upd_cnt - base !== 1) begin
            tests_failed++;
            $display("FAIL single_pulses: got %0d update pulses, want 1", upd_cnt - base);
        end
    endtask

    task automatic test_scan();
        int base;
        base = upd_cnt;
        hold(8'hF9, 4'hE, 8); idle(2);   // 1 on digit 0
        hold(8'h88, 4'hD, 8); idle(2);   // A on digit 1
        hold(8'h21, 4'hB, 8); idle(2);   // d with dot on digit 2
        hold(8'h8E, 4'h7, 8); idle(8);   // F on digit 3
        tests_run++;
        if (bus.digits !== 16'hFDA1 || bus.dots !== 4'b0100 || bus.invalid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL scan_values: got digits=%h dots=%b invalid=%b, want FDA1 0100 0000",
                     bus.digits, bus.dots, bus.invalid);
        end
        tests_run++;
        if (upd_cnt - base !== 4) begin
            tests_failed++;
            $display("FAIL scan_pulses: got %0d update pulses, want 4", upd_cnt - base);
        end
    endtask

    task automatic test_invalid_and_short();
        int base;
        base = upd_cnt;
        hold(8'hFF, 4'hB, 8); idle(4);   // unmatched pattern 7F, dot off, digit 2
        tests_run++;
        if (bus.digits !== 16'hF0A1 || bus.invalid !== 4'b0100 || bus.dots !== 4'b0000) begin
            tests_failed++;
            $display("FAIL invalid_glyph: got digits=%h invalid=%b dots=%b, want F0A1 0100 0000",
                     bus.digits, bus.invalid, bus.dots);
        end
        tests_run++;
        if (upd_cnt - base !== 1) begin
            tests_failed++;
            $display("FAIL invalid_pulse: got %0d update pulses, want 1", upd_cnt - base);
        end
        base = upd_cnt;
        hold(8'hA1, 4'hB, 3); idle(10);  // d held only 3 samples
        tests_run++;
        if (bus.digits !== 16'hF0A1 || bus.invalid !== 4'b0100 || upd_cnt - base !== 0) begin
            tests_failed++;
            $display("FAIL short_hold: got digits=%h invalid=%b pulses=%0d, want F0A1 0100 0",
                     bus.digits, bus.invalid, upd_cnt - base);
        end
        base = upd_cnt;
        hold(8'hC0, 4'h7, 4); idle(10);  // 0 on digit 3 held exactly 4 samples
        tests_run++;
        if (bus.digits !== 16'h00A1 || bus.invalid !== 4'b0100 || upd_cnt - base !== 1) begin
            tests_failed++;
            $display("FAIL exact_hold: got digits=%h invalid=%b pulses=%0d, want 00A1 0100 1",
                     bus.digits, bus.invalid, upd_cnt - base);
        end
    endtask

    task automatic test_ghost_and_reset();
        int base;
        base = upd_cnt;
        hold(8'hC0, 4'hC, 10); idle(8);  // two digits selected
        tests_run++;
        if (bus.digits !== 16'h00A1 || bus.dots !== 4'b0000 || bus.invalid !== 4'b0100 || upd_cnt - base !== 0) begin
            tests_failed++;
            $display("FAIL ghosting: got digits=%h dots=%b invalid=%b pulses=%0d, want 00A1 0000 0100 0",
                     bus.digits, bus.dots, bus.invalid, upd_cnt - base);
        end
        hold(8'h92, 4'hD, 2);            // partial pattern on digit 1
        reset_n = 1'b0;
        bus.seg_n = 8'hFF;
        bus.dig_n = 4'hF;
        @(negedge clock);
        reset_n = 1'b1;
        tests_run++;
        if (bus.digits !== 16'h0000 || bus.dots !== 4'h0 || bus.invalid !== 4'hF || bus.update !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: got digits=%h dots=%b invalid=%b update=%b, want 0000 0000 1111 0",
                     bus.digits, bus.dots, bus.invalid, bus.update);
        end
        base = upd_cnt;
        idle(10);
        tests_run++;
        if (bus.digits !== 16'h0000 || bus.invalid !== 4'hF || upd_cnt - base !== 0) begin
            tests_failed++;
            $display("FAIL post_reset: got digits=%h invalid=%b pulses=%0d, want 0000 1111 0",
                     bus.digits, bus.invalid, upd_cnt - base);
        end
    endtask

    task automatic test_loopback();
        logic [6:0] glyph;
        for (int v = 0; v < 16; v++) begin
            for (int c = 0; c < 2; c++) begin
                glyph = ENC[v];
                hold({~1'(c), glyph}, 4'hE, 8);
                tests_run++;
                if (bus.digits[3:0] !== 4'(v) || bus.dots[0] !== 1'(c) || bus.invalid[0] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL loopback v=%0d c=%0d: got digit0=%h dot0=%b invalid0=%b",
                             v, c, bus.digits[3:0], bus.dots[0], bus.invalid[0]);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset_n   = 1'b0;
        bus.seg_n = 8'hFF;
        bus.dig_n = 4'hF;
        @(negedge clock);
        test_reset();
        test_single_digit();
        test_scan();
        test_invalid_and_short();
        test_ghost_and_reset();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
